// File: rtl/seq_multiplier.sv
// Purpose : iterative shift-add unsigned multiplier, B x B -> 2B, one add per cycle.
// Latency : B+1 cycles from accepting edge to done (1..B+1 with SEQ_MUL_EARLY_TERM_EN).
// Backpres: start is only honoured while busy=0; starts during busy are dropped.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, a, b     request + operands, captured on the accepting edge
//   busy            high while iterating
//   done            one-cycle pulse, product valid
//   product         {P_hi,P_lo}; stable from done until the next accepted start
//
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the unconsumed multiplier
// bits are all zero, aligning the partial product with one right shift.

// Carry-skip adder: ripple inside 4-bit blocks, a block whose bits all propagate
// forwards its incoming carry directly. Handles a short final block when W%4 != 0.
module csk_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int BLK = 4;

  always_comb begin : csk
    logic c;
    logic p;
    logic blk_cin;
    logic blk_p;
    sum     = '0;
    c       = cin;
    p       = 1'b0;
    blk_cin = cin;
    blk_p   = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i % BLK == 0) begin
        blk_cin = c;
        blk_p   = 1'b1;
      end
      p      = x[i] ^ y[i];
      sum[i] = p ^ c;
      c      = (x[i] & y[i]) | (p & c);
      blk_p  = blk_p & p;
      if ((i % BLK == BLK - 1) || (i == W - 1))
        c = blk_p ? blk_cin : c;
    end
    cout = c;
  end
endmodule

module seq_multiplier #(
  parameter int B = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [B-1:0]   a,
  input  logic [B-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*B-1:0] product
);
  localparam int CW = $clog2(B) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [B-1:0]   mcand;
  logic [B-1:0]   p_hi;
  logic [B-1:0]   p_lo;
  logic [CW-1:0]  count;

  logic [B-1:0]   addend;
  logic [B-1:0]   sum;
  logic           cout;
  logic [2*B-1:0] p_next;
  logic [2*B-1:0] p_fin;
  logic           last_iter;
  logic           finish;
  logic           b_zero;

  assign addend = p_lo[0] ? mcand : '0;

  csk_adder #(.W(B)) u_add (
    .x   (p_hi),
    .y   (addend),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  // Carry-out becomes the new MSB, so no product bit is ever lost.
  assign p_next    = {cout, sum, p_lo[B-1:1]};
  assign last_iter = (count == CW'(B - 1));
  assign product   = {p_hi, p_lo};

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [CW-1:0] consumed;
  logic [CW-1:0] remain;
  logic          rest_zero;

  // After this iteration the not-yet-consumed multiplier bits sit in
  // p_next[B-1-consumed:0]; if they are zero the remaining iterations would
  // only add zero and shift, so shift by the remaining count in one go.
  assign consumed  = count + CW'(1);
  assign remain    = CW'(B) - consumed;
  assign rest_zero = ((p_next[B-1:0] & ({B{1'b1}} >> consumed)) == '0);
  assign p_fin     = p_next >> remain;
  assign finish    = last_iter | rest_zero;
  assign b_zero    = (b == '0);
`else
  assign p_fin     = p_next;
  assign finish    = last_iter;
  assign b_zero    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      count <= '0;
    end else begin
      case (state)
        BUSY: begin
          {p_hi, p_lo} <= finish ? p_fin : p_next;
          count        <= count + CW'(1);
          if (finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE always drops after one cycle.
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            p_hi  <= '0;
            p_lo  <= b;
            count <= '0;
            if (b_zero) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
